// File: rtl/slave_mem_param_if.sv
// slave_mem_param_if
// Bus bundle between the interconnect/master and a memory-backed slave.
// Signals:
//   sl_select, m_valid, mode, addr, wdata : request side, driven by the master
//   rdata, sl_valid, sl_ready, sl_err     : response side, driven by the slave
// Modports: master (drives requests), slave (drives responses).
interface slave_mem_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) ();
  logic              sl_select;
  logic              m_valid;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              sl_valid;
  logic              sl_ready;
  logic              sl_err;

  modport master (
    output sl_select, m_valid, mode, addr, wdata,
    input  rdata, sl_valid, sl_ready, sl_err
  );

  modport slave (
    input  sl_select, m_valid, mode, addr, wdata,
    output rdata, sl_valid, sl_ready, sl_err
  );
endinterface

// File: rtl/slave_mem_param.sv
// slave_mem_param
// Memory-backed single-beat bus slave with a fixed wait latency, address-window
// decode and an error response for accesses outside the window.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of slave_mem_param_if:
//        sl_select/m_valid/mode/addr/wdata in, rdata/sl_valid/sl_ready/sl_err out
// Every output is a register. The storage array is not reset.
module slave_mem_param #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  slave_mem_param_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              mode_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              sl_valid_r;
  logic              sl_ready_r;
  logic              sl_err_r;

  logic [DATA_W-1:0] store_r [MEM_DEPTH];

  logic [ADDR_W-1:0] off_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic              commit_s;
  logic              mem_we_s;

  // Decode works on the latched address; the subtraction may wrap, so the
  // lower-bound test is done on the raw address.
  assign off_s      = addr_r - BASE_ADDR;
  assign in_range_s = (addr_r >= BASE_ADDR) && ({1'b0, off_s} < DEPTH_EXT);
  assign idx_s      = off_s[IDX_W-1:0];
  assign commit_s   = (state_r == S_WAIT) && (cnt_r == WAIT_LAST);
  // state_r is cleared asynchronously, so a reset inside WAIT drops the write.
  assign mem_we_s   = commit_s && mode_r && in_range_s;

  assign bus.rdata    = rdata_r;
  assign bus.sl_valid = sl_valid_r;
  assign bus.sl_ready = sl_ready_r;
  assign bus.sl_err   = sl_err_r;

  // Storage write port, written only on an in-range write commit.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      store_r[idx_s] <= wdata_r;
    end
  end

  // Transfer FSM with registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      mode_r     <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      sl_valid_r <= 1'b0;
      sl_ready_r <= 1'b1;
      sl_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          sl_valid_r <= 1'b0;
          sl_err_r   <= 1'b0;
          if (bus.sl_select && bus.m_valid) begin
            mode_r     <= bus.mode;
            addr_r     <= bus.addr;
            wdata_r    <= bus.wdata;
            cnt_r      <= CNT_ONE;
            sl_ready_r <= 1'b0;
            state_r    <= S_WAIT;
          end else begin
            sl_ready_r <= 1'b1;
          end
        end
        S_WAIT: begin
          sl_ready_r <= 1'b0;
          if (commit_s) begin
            if (in_range_s) begin
              rdata_r  <= mode_r ? wdata_r : store_r[idx_s];
              sl_err_r <= 1'b0;
            end else begin
              rdata_r  <= '0;
              sl_err_r <= 1'b1;
            end
            sl_valid_r <= 1'b1;
            cnt_r      <= '0;
            state_r    <= S_RESP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_RESP: begin
          // Ready rises here so the next accept lands one edge later.
          sl_valid_r <= 1'b0;
          sl_err_r   <= 1'b0;
          sl_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          sl_valid_r <= 1'b0;
          sl_err_r   <= 1'b0;
          sl_ready_r <= 1'b1;
          cnt_r      <= '0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_mem_param.sv
// tb_slave_mem_param
// Bench for slave_mem_param: instance A uses the default parameters, instance B
// uses DATA_W=16, BASE_ADDR=0x4000, WAIT_CYCLES=1. Expected values come from an
// associative-array memory model and the latency rules of the slave.
module tb_slave_mem_param;

  localparam int WA = 3;
  localparam int WB = 1;
  localparam int BASE_A = 0;
  localparam int BASE_B = 16'h4000;
  localparam int DEPTH  = 256;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0]  ref_a [int];
  logic [15:0] ref_b [int];

  slave_mem_param_if #(.DATA_W(8),  .ADDR_W(16)) ifa ();
  slave_mem_param_if #(.DATA_W(16), .ADDR_W(16)) ifb ();

  slave_mem_param #(
    .DATA_W(8), .ADDR_W(16), .MEM_DEPTH(DEPTH), .BASE_ADDR(16'h0000), .WAIT_CYCLES(WA)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  slave_mem_param #(
    .DATA_W(16), .ADDR_W(16), .MEM_DEPTH(DEPTH), .BASE_ADDR(16'h4000), .WAIT_CYCLES(WB)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic bit in_win(input int a, input int base);
    return (a >= base) && (a < base + DEPTH);
  endfunction

  // One transfer on A; inputs are scrambled while the slave must ignore them.
  task automatic xfer_a(input logic m, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int lat,
                        output int npulse, output int rdy_low);
    lat = -1; npulse = 0; rdy_low = 0; rd = 8'h00; er = 1'b0;
    ifa.sl_select = 1'b1; ifa.m_valid = 1'b1; ifa.mode = m; ifa.addr = a; ifa.wdata = d;
    @(posedge clk);
    for (int k = 0; k <= WA + 3; k++) begin
      #1;
      if (!ifa.sl_ready) rdy_low++;
      if (ifa.sl_valid) begin
        npulse++; lat = k; rd = ifa.rdata; er = ifa.sl_err;
      end
      if (k <= WA) begin
        ifa.sl_select = 1'($urandom); ifa.m_valid = 1'($urandom); ifa.mode = 1'($urandom);
        ifa.addr = 16'($urandom); ifa.wdata = 8'($urandom);
      end else begin
        ifa.sl_select = 1'b0; ifa.m_valid = 1'b0; ifa.mode = 1'b0;
      end
      @(posedge clk);
    end
    #1;
  endtask

  // One transfer on B, same shape as xfer_a.
  task automatic xfer_b(input logic m, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er, output int lat,
                        output int npulse, output int rdy_low);
    lat = -1; npulse = 0; rdy_low = 0; rd = 16'h0000; er = 1'b0;
    ifb.sl_select = 1'b1; ifb.m_valid = 1'b1; ifb.mode = m; ifb.addr = a; ifb.wdata = d;
    @(posedge clk);
    for (int k = 0; k <= WB + 3; k++) begin
      #1;
      if (!ifb.sl_ready) rdy_low++;
      if (ifb.sl_valid) begin
        npulse++; lat = k; rd = ifb.rdata; er = ifb.sl_err;
      end
      if (k <= WB) begin
        ifb.sl_select = 1'($urandom); ifb.m_valid = 1'($urandom); ifb.mode = 1'($urandom);
        ifb.addr = 16'($urandom); ifb.wdata = 16'($urandom);
      end else begin
        ifb.sl_select = 1'b0; ifb.m_valid = 1'b0; ifb.mode = 1'b0;
      end
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] rd; logic er; int lat, np, rl;
    #2;
    total++; if (ifa.rdata !== 8'h00 || ifa.sl_valid !== 1'b0 || ifa.sl_ready !== 1'b1 || ifa.sl_err !== 1'b0) begin
      bad++; $display("FAIL reset_initial got rdata=%h v=%b r=%b e=%b exp 00 0 1 0", ifa.rdata, ifa.sl_valid, ifa.sl_ready, ifa.sl_err);
    end
    @(posedge clk); #1; rst = 1'b0;
    xfer_a(1'b1, 16'h0033, 8'h5A, rd, er, lat, np, rl);
    ref_a[16'h0033] = 8'h5A;
    total++; if (ifa.rdata !== 8'h5A) begin
      bad++; $display("FAIL reset_hold_before got=%h exp=5a", ifa.rdata);
    end
    // Start a read, then reset mid-cycle while it waits.
    ifa.sl_select = 1'b1; ifa.m_valid = 1'b1; ifa.mode = 1'b0; ifa.addr = 16'h0033;
    @(posedge clk); #1;
    ifa.sl_select = 1'b0; ifa.m_valid = 1'b0;
    total++; if (ifa.sl_ready !== 1'b0) begin
      bad++; $display("FAIL reset_busy_ready got=%b exp=0", ifa.sl_ready);
    end
    #1 rst = 1'b1;
    #1;
    total++; if (ifa.rdata !== 8'h00 || ifa.sl_valid !== 1'b0 || ifa.sl_ready !== 1'b1 || ifa.sl_err !== 1'b0) begin
      bad++; $display("FAIL reset_async got rdata=%h v=%b r=%b e=%b exp 00 0 1 0", ifa.rdata, ifa.sl_valid, ifa.sl_ready, ifa.sl_err);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic er; int lat, np, rl;
    xfer_a(1'b1, 16'h0010, 8'hA5, rd, er, lat, np, rl);
    ref_a[16'h0010] = 8'hA5;
    total++; if (rd !== 8'hA5 || er !== 1'b0) begin
      bad++; $display("FAIL wr_echo got=%h err=%b exp=a5 err=0", rd, er);
    end
    total++; if (lat !== WA || np !== 1 || rl !== WA + 1) begin
      bad++; $display("FAIL wr_timing got lat=%0d pulses=%0d rdylow=%0d exp %0d 1 %0d", lat, np, rl, WA, WA + 1);
    end
    xfer_a(1'b0, 16'h0010, 8'h00, rd, er, lat, np, rl);
    total++; if (rd !== ref_a[16'h0010] || er !== 1'b0) begin
      bad++; $display("FAIL rd_data got=%h err=%b exp=%h err=0", rd, er, ref_a[16'h0010]);
    end
    total++; if (lat !== WA || np !== 1) begin
      bad++; $display("FAIL rd_timing got lat=%0d pulses=%0d exp %0d 1", lat, np, WA);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd; logic er; int lat, np, rl; logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    xfer_a(1'b1, 16'h0000, v, rd, er, lat, np, rl);
    ref_a[0] = v;
    xfer_a(1'b0, 16'h0100, 8'h00, rd, er, lat, np, rl);
    total++; if (rd !== 8'h00 || er !== 1'b1 || np !== 1) begin
      bad++; $display("FAIL oor_read got=%h err=%b pulses=%0d exp=00 err=1 pulses=1", rd, er, np);
    end
    xfer_a(1'b1, 16'h0100, ~v, rd, er, lat, np, rl);
    total++; if (rd !== 8'h00 || er !== 1'b1) begin
      bad++; $display("FAIL oor_write got=%h err=%b exp=00 err=1", rd, er);
    end
    xfer_a(1'b0, 16'h0000, 8'h00, rd, er, lat, np, rl);
    total++; if (rd !== ref_a[0] || er !== 1'b0) begin
      bad++; $display("FAIL oor_word0_intact got=%h err=%b exp=%h err=0", rd, er, ref_a[0]);
    end
    xfer_a(1'b0, 16'hFFFF, 8'h00, rd, er, lat, np, rl);
    total++; if (rd !== 8'h00 || er !== 1'b1) begin
      bad++; $display("FAIL oor_top got=%h err=%b exp=00 err=1", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int accepts[$]; int pulses; int ready_bad; int valid_bad; logic exp_low; logic exp_v; int a;
    for (a = 0; a <= 9; a += WA + 2) accepts.push_back(a);
    pulses = 0; ready_bad = 0; valid_bad = 0;
    ifa.sl_select = 1'b1; ifa.m_valid = 1'b1; ifa.mode = 1'b0; ifa.addr = 16'h0010;
    for (int i = 0; i <= 16; i++) begin
      @(posedge clk); #1;
      exp_low = 1'b0; exp_v = 1'b0;
      foreach (accepts[j]) begin
        if (i >= accepts[j] && i <= accepts[j] + WA) exp_low = 1'b1;
        if (i == accepts[j] + WA) exp_v = 1'b1;
      end
      if (ifa.sl_ready !== !exp_low) ready_bad++;
      if (ifa.sl_valid !== exp_v) valid_bad++;
      if (ifa.sl_valid === 1'b1) begin
        pulses++;
        if (ifa.rdata !== ref_a[16'h0010]) valid_bad++;
      end
      if (i == 9) begin
        ifa.sl_select = 1'b0; ifa.m_valid = 1'b0;
      end
    end
    total++; if (pulses !== accepts.size()) begin
      bad++; $display("FAIL b2b_accepts got=%0d exp=%0d", pulses, accepts.size());
    end
    total++; if (ready_bad !== 0 || valid_bad !== 0) begin
      bad++; $display("FAIL b2b_timing got ready_errs=%0d valid_errs=%0d exp 0 0", ready_bad, valid_bad);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd; logic er; int lat, np, rl; logic m; int a; logic [7:0] d;
    logic [7:0] exp_rd; logic exp_er; int errs;
    errs = 0;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(256, 16'hFFFF)) : int'($urandom_range(0, 255));
      m = 1'($urandom);
      d = 8'($urandom);
      if (!m && in_win(a, BASE_A) && !ref_a.exists(a - BASE_A)) m = 1'b1;
      if (!in_win(a, BASE_A)) begin
        exp_rd = 8'h00; exp_er = 1'b1;
      end else if (m) begin
        exp_rd = d; exp_er = 1'b0; ref_a[a - BASE_A] = d;
      end else begin
        exp_rd = ref_a[a - BASE_A]; exp_er = 1'b0;
      end
      xfer_a(m, 16'(a), d, rd, er, lat, np, rl);
      if (rd !== exp_rd || er !== exp_er || lat !== WA || np !== 1) begin
        errs++;
        $display("FAIL rand_xfer addr=%h mode=%b got=%h err=%b lat=%0d exp=%h err=%b lat=%0d", a, m, rd, er, lat, exp_rd, exp_er, WA);
      end
    end
    total++; if (errs !== 0) begin
      bad++; $display("FAIL rand_summary got errs=%0d exp=0", errs);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd; logic er; int lat, np, rl;
    xfer_a(1'b1, 16'h0020, 8'h11, rd, er, lat, np, rl);
    ref_a[16'h0020] = 8'h11;
    ifa.sl_select = 1'b1; ifa.m_valid = 1'b1; ifa.mode = 1'b1; ifa.addr = 16'h0020; ifa.wdata = 8'h77;
    @(posedge clk); #1;
    ifa.sl_select = 1'b0; ifa.m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    xfer_a(1'b0, 16'h0020, 8'h00, rd, er, lat, np, rl);
    total++; if (rd !== ref_a[16'h0020] || er !== 1'b0 || np !== 1) begin
      bad++; $display("FAIL abort_write_dropped got=%h err=%b pulses=%0d exp=%h err=0 pulses=1", rd, er, np, ref_a[16'h0020]);
    end
  endtask

  task automatic test_param_b();
    logic [15:0] rd; logic er; int lat, np, rl; logic [15:0] v;
    xfer_b(1'b1, 16'h4003, 16'hBEEF, rd, er, lat, np, rl);
    ref_b[3] = 16'hBEEF;
    total++; if (rd !== 16'hBEEF || er !== 1'b0 || lat !== WB || np !== 1 || rl !== WB + 1) begin
      bad++; $display("FAIL b_write got=%h err=%b lat=%0d pulses=%0d rdylow=%0d exp=beef 0 %0d 1 %0d", rd, er, lat, np, rl, WB, WB + 1);
    end
    xfer_b(1'b0, 16'h4003, 16'h0000, rd, er, lat, np, rl);
    total++; if (rd !== ref_b[3] || er !== 1'b0 || lat !== WB) begin
      bad++; $display("FAIL b_read got=%h err=%b lat=%0d exp=%h 0 %0d", rd, er, lat, ref_b[3], WB);
    end
    xfer_b(1'b0, 16'h3FFF, 16'h0000, rd, er, lat, np, rl);
    total++; if (rd !== 16'h0000 || er !== (in_win(16'h3FFF, BASE_B) ? 1'b0 : 1'b1)) begin
      bad++; $display("FAIL b_below_base got=%h err=%b exp=0000 err=1", rd, er);
    end
    xfer_b(1'b0, 16'h4100, 16'h0000, rd, er, lat, np, rl);
    total++; if (rd !== 16'h0000 || er !== 1'b1) begin
      bad++; $display("FAIL b_above_top got=%h err=%b exp=0000 err=1", rd, er);
    end
    v = 16'($urandom);
    xfer_b(1'b1, 16'h40FF, v, rd, er, lat, np, rl);
    ref_b[255] = v;
    xfer_b(1'b0, 16'h40FF, 16'h0000, rd, er, lat, np, rl);
    total++; if (rd !== ref_b[255] || er !== 1'b0) begin
      bad++; $display("FAIL b_last_word got=%h err=%b exp=%h err=0", rd, er, ref_b[255]);
    end
    xfer_b(1'b0, 16'h4003, 16'h0000, rd, er, lat, np, rl);
    total++; if (rd !== ref_b[3] || er !== 1'b0) begin
      bad++; $display("FAIL b_word3_intact got=%h err=%b exp=%h err=0", rd, er, ref_b[3]);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    ifa.sl_select = 1'b0; ifa.m_valid = 1'b0; ifa.mode = 1'b0; ifa.addr = 16'h0000; ifa.wdata = 8'h00;
    ifb.sl_select = 1'b0; ifb.m_valid = 1'b0; ifb.mode = 1'b0; ifb.addr = 16'h0000; ifb.wdata = 16'h0000;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_param_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
